// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pipe_state_t;

    // Back-end cycles after a HALT reaches ID, and the width of the counter
    // that tracks them (holds up to 15).
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int DRAIN_CNT_W      = 4;

    // Width of the saturating stall counter.
    localparam int STALL_CNT_W = 16;

    // Saturating increment for the stall counter.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs and stage enable/flush outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; the enables themselves are the stall mechanism.
// Ports: master = pipeline datapath (drives hazard info, consumes enables);
//        slave  = pipe_ctrl (consumes hazard info, drives enables/status).
interface pipe_ctrl_if #(
    parameter int REG_BITS = 3
);
    import pipe_ctrl_pkg::*;

    logic [REG_BITS-1:0]    ifid_rs;
    logic [REG_BITS-1:0]    ifid_rt;
    logic                   ifid_uses_rs;
    logic                   ifid_uses_rt;
    logic                   idex_memread;
    logic [REG_BITS-1:0]    idex_rd;
    logic                   branch_taken;
    logic                   halt_id;
    logic                   imem_stall;
    logic                   dmem_stall;

    logic                   pc_en;
    logic                   ifid_en;
    logic                   ifid_nop;
    logic                   idex_en;
    logic                   idex_nop;
    logic                   back_en;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
               idex_memread, idex_rd, branch_taken, halt_id,
               imem_stall, dmem_stall,
        input  pc_en, ifid_en, ifid_nop, idex_en, idex_nop,
               back_en, halted, stall_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
               idex_memread, idex_rd, branch_taken, halt_id,
               imem_stall, dmem_stall,
        output pc_en, ifid_en, ifid_nop, idex_en, idex_nop,
               back_en, halted, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID instruction and a load in EX.
// Latency: combinational, 0 cycles.
// Backpressure: none; result feeds the stall logic in pipe_ctrl.
// Ports: ifid_rs/rt + uses flags (ID sources), idex_memread/idex_rd (EX load), load_use (out).
module hazard_detect #(
    parameter int REG_BITS = 3
) (
    input  logic [REG_BITS-1:0] ifid_rs,
    input  logic [REG_BITS-1:0] ifid_rt,
    input  logic                ifid_uses_rs,
    input  logic                ifid_uses_rt,
    input  logic                idex_memread,
    input  logic [REG_BITS-1:0] idex_rd,
    output logic                load_use
);

    // Only sources the ID instruction actually reads can create a hazard.
    assign load_use = idex_memread &
                      ((ifid_uses_rs & (ifid_rs == idex_rd)) |
                       (ifid_uses_rt & (ifid_rt == idex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stalls, flushes, redirect wait and halt drain.
// Latency: enables/nops combinational from state+inputs; halted/stall_cnt registered (1 cycle).
// Backpressure: dmem_stall freezes the whole pipe; imem_stall/load-use stall the front end.
// Ports: clk, rst (sync, active-high); pif (slave modport) carries hazard inputs and stage controls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS     = 3,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    pif
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    pipe_state_t            state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   halted_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic pc_en, ifid_en, ifid_nop, idex_en, idex_nop, back_en;

    hazard_detect #(
        .REG_BITS (REG_BITS)
    ) u_hazard (
        .ifid_rs      (pif.ifid_rs),
        .ifid_rt      (pif.ifid_rt),
        .ifid_uses_rs (pif.ifid_uses_rs),
        .ifid_uses_rt (pif.ifid_uses_rt),
        .idex_memread (pif.idex_memread),
        .idex_rd      (pif.idex_rd),
        .load_use     (load_use)
    );

    // Stage controls.
    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_nop = 1'b0;
        idex_en  = 1'b1;
        idex_nop = 1'b0;
        back_en  = 1'b1;
        unique case (state)
            ST_RUN: begin
                if (pif.dmem_stall) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    back_en = 1'b0;
                end else if (pif.branch_taken) begin
                    // Kill both younger instructions; PC takes the target.
                    ifid_nop = 1'b1;
                    idex_nop = 1'b1;
                end else if (pif.halt_id) begin
                    pc_en    = 1'b0;
                    ifid_nop = 1'b1;
                end else if (load_use) begin
                    // Hold IF/ID so the consumer retries once the load is in MEM.
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_nop = 1'b1;
                end else if (pif.imem_stall) begin
                    pc_en    = 1'b0;
                    ifid_nop = 1'b1;
                end
            end
            ST_REDIR: begin
                if (pif.dmem_stall) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    back_en = 1'b0;
                end else begin
                    // The fetch in flight is from the wrong path, even on the
                    // cycle it completes, so it is always discarded.
                    pc_en    = 1'b0;
                    ifid_nop = 1'b1;
                    idex_nop = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_en    = 1'b0;
                ifid_nop = 1'b1;
                idex_nop = 1'b1;
                back_en  = ~pif.dmem_stall;
            end
            ST_HALTED: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
                back_en = 1'b0;
            end
            default: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
                back_en = 1'b0;
            end
        endcase
    end

    // State, drain counter and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (((state == ST_RUN) || (state == ST_REDIR)) && !pc_en)
                stall_cnt_q <= sat_inc(stall_cnt_q);

            unique case (state)
                ST_RUN: begin
                    if (!pif.dmem_stall) begin
                        // A branch outranks halt: the HALT in ID is on the wrong path.
                        if (pif.branch_taken) begin
                            if (pif.imem_stall)
                                state <= ST_REDIR;
                        end else if (pif.halt_id) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_REDIR: begin
                    if (!pif.dmem_stall && !pif.imem_stall)
                        state <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (!pif.dmem_stall) begin
                        if (drain_cnt == '0) begin
                            state    <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign pif.pc_en     = pc_en;
    assign pif.ifid_en   = ifid_en;
    assign pif.ifid_nop  = ifid_nop;
    assign pif.idex_en   = idex_en;
    assign pif.idex_nop  = idex_nop;
    assign pif.back_en   = back_en;
    assign pif.halted    = halted_q;
    assign pif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, redirect, drain/halt, reset, counter saturation.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_BITS(3)) pif ();

    pipe_ctrl #(
        .REG_BITS     (3),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    int total = 0;
    int bad   = 0;

    // Packed view: {pc_en, ifid_en, ifid_nop, idex_en, idex_nop, back_en, halted}
    logic [6:0] ctl;
    assign ctl = {pif.pc_en, pif.ifid_en, pif.ifid_nop, pif.idex_en,
                  pif.idex_nop, pif.back_en, pif.halted};

    localparam logic [6:0] CTL_RUN    = 7'b1101010;
    localparam logic [6:0] CTL_LU     = 7'b0001110;
    localparam logic [6:0] CTL_FLUSH  = 7'b1111110;
    localparam logic [6:0] CTL_FETCH  = 7'b0111010; // imem stall or halt in RUN
    localparam logic [6:0] CTL_FREEZE = 7'b0000000;
    localparam logic [6:0] CTL_KILL   = 7'b0111110; // REDIR or DRAIN
    localparam logic [6:0] CTL_DRSTL  = 7'b0111100; // DRAIN with dmem stall
    localparam logic [6:0] CTL_HALTED = 7'b0000001;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pif.ifid_rs      = 3'd0;
        pif.ifid_rt      = 3'd0;
        pif.ifid_uses_rs = 1'b0;
        pif.ifid_uses_rt = 1'b0;
        pif.idex_memread = 1'b0;
        pif.idex_rd      = 3'd0;
        pif.branch_taken = 1'b0;
        pif.halt_id      = 1'b0;
        pif.imem_stall   = 1'b0;
        pif.dmem_stall   = 1'b0;
    endtask

    // Advance one clock; inputs change and are sampled 1-2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_ctl", 16'(ctl), 16'(CTL_RUN));
        chk("reset_cnt", pif.stall_cnt, 16'd0);

        // Load-use compare variants (combinational only, no edge).
        pif.idex_memread = 1'b1; pif.idex_rd = 3'd3;
        pif.ifid_rs = 3'd2; pif.ifid_uses_rs = 1'b1;
        #1; chk("lu_nomatch", 16'(ctl), 16'(CTL_RUN));
        pif.ifid_rs = 3'd3; pif.ifid_uses_rs = 1'b0;
        #1; chk("lu_unused", 16'(ctl), 16'(CTL_RUN));
        pif.ifid_uses_rs = 1'b1; pif.idex_memread = 1'b0;
        #1; chk("lu_noload", 16'(ctl), 16'(CTL_RUN));
        pif.ifid_uses_rs = 1'b0; pif.idex_memread = 1'b1;
        pif.ifid_rt = 3'd3; pif.ifid_uses_rt = 1'b1;
        #1; chk("lu_rt", 16'(ctl), 16'(CTL_LU));
        idle();

        // Load-use on rs for one cycle.
        pif.idex_memread = 1'b1; pif.idex_rd = 3'd3;
        pif.ifid_rs = 3'd3; pif.ifid_uses_rs = 1'b1;
        #1; chk("lu_rs", 16'(ctl), 16'(CTL_LU));
        tick();
        idle();
        #1;
        chk("lu_after", 16'(ctl), 16'(CTL_RUN));
        chk("lu_cnt", pif.stall_cnt, 16'd1);

        // Branch with fetch idle.
        pif.branch_taken = 1'b1;
        #1; chk("br_idle", 16'(ctl), 16'(CTL_FLUSH));
        tick();
        idle();
        #1;
        chk("br_idle_next", 16'(ctl), 16'(CTL_RUN));
        chk("br_idle_cnt", pif.stall_cnt, 16'd1);

        // Branch with fetch busy for 3 cycles, then release.
        pif.branch_taken = 1'b1; pif.imem_stall = 1'b1;
        #1; chk("br_busy", 16'(ctl), 16'(CTL_FLUSH));
        tick();
        pif.branch_taken = 1'b0;
        #1; chk("redir_1", 16'(ctl), 16'(CTL_KILL));
        tick();
        #1; chk("redir_2", 16'(ctl), 16'(CTL_KILL));
        tick();
        pif.imem_stall = 1'b0;
        #1; chk("redir_rel", 16'(ctl), 16'(CTL_KILL));
        tick();
        #1;
        chk("redir_run", 16'(ctl), 16'(CTL_RUN));
        chk("redir_cnt", pif.stall_cnt, 16'd4);

        // Plain imem stall, then dmem freeze.
        pif.imem_stall = 1'b1;
        #1; chk("imem", 16'(ctl), 16'(CTL_FETCH));
        tick();
        idle();
        pif.dmem_stall = 1'b1; pif.imem_stall = 1'b1;
        #1; chk("dmem", 16'(ctl), 16'(CTL_FREEZE));
        tick();
        idle();
        #1; chk("dmem_cnt", pif.stall_cnt, 16'd6);

        // Branch + halt + dmem together, then branch + halt once dmem drops.
        pif.branch_taken = 1'b1; pif.halt_id = 1'b1; pif.dmem_stall = 1'b1;
        #1; chk("sim_freeze", 16'(ctl), 16'(CTL_FREEZE));
        tick();
        pif.dmem_stall = 1'b0;
        #1; chk("sim_flush", 16'(ctl), 16'(CTL_FLUSH));
        tick();
        idle();
        #1;
        chk("sim_no_drain", 16'(ctl), 16'(CTL_RUN));
        chk("sim_cnt", pif.stall_cnt, 16'd7);

        // Halt with a 2-cycle dmem stall mid-drain.
        pif.halt_id = 1'b1;
        #1; chk("halt", 16'(ctl), 16'(CTL_FETCH));
        tick();
        idle();
        pif.branch_taken = 1'b1; pif.halt_id = 1'b1;
        pif.idex_memread = 1'b1; pif.ifid_uses_rs = 1'b1; // load-use also present
        #1; chk("drain_1", 16'(ctl), 16'(CTL_KILL));
        tick();
        idle();
        pif.dmem_stall = 1'b1;
        #1; chk("drain_st1", 16'(ctl), 16'(CTL_DRSTL));
        tick();
        #1; chk("drain_st2", 16'(ctl), 16'(CTL_DRSTL));
        tick();
        pif.dmem_stall = 1'b0;
        #1; chk("drain_4", 16'(ctl), 16'(CTL_KILL));
        tick();
        #1; chk("drain_5", 16'(ctl), 16'(CTL_KILL));
        tick();
        #1;
        chk("halted", 16'(ctl), 16'(CTL_HALTED));
        chk("halted_cnt", pif.stall_cnt, 16'd8);
        pif.branch_taken = 1'b1; pif.imem_stall = 1'b1; pif.halt_id = 1'b1;
        tick();
        #1; chk("halted_hold", 16'(ctl), 16'(CTL_HALTED));
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_halt_ctl", 16'(ctl), 16'(CTL_RUN));
        chk("rst_halt_cnt", pif.stall_cnt, 16'd0);

        // Saturation: 65534 stall cycles, then 6 more.
        pif.imem_stall = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        #1; chk("sat_near", pif.stall_cnt, 16'hFFFE);
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("sat_hold", pif.stall_cnt, 16'hFFFF);
        chk("sat_ctl", 16'(ctl), 16'(CTL_FETCH));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
